// File: rtl/detector_coliziune_pkg.sv
// Shared game constants and state encoding so the obstacle generator,
// the collision detector and the renderer agree on geometry and states.
package detector_coliziune_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_HIT       = 2'd2,
    ST_GAME_OVER = 2'd3
  } stare_t;

  // Geometry is kept 12 bits wide so x + width and gap + height never wrap
  localparam logic [11:0] LUNGIME_ECRAN   = 12'd1920;
  localparam logic [11:0] LATIME_OBSTACOL = 12'd50;
  localparam logic [11:0] X_PLAYER        = 12'd400;
  localparam logic [11:0] PLAYER_SIZE     = 12'd40;
  localparam logic [11:0] GAP_H           = 12'd300;
  localparam logic [4:0]  HIT_TICKS       = 5'd25;

  localparam logic [11:0] BCD_MAX = 12'h999;

  function automatic logic [3:0] bcdDigitInc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/detector_coliziune_contor_bcd3.sv
// Three-digit BCD counter with clear, increment and saturation at 999;
// shared with the on-screen score display.
module contor_bcd3
  import detector_coliziune_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clr,
  input  logic        i_inc,
  output logic [11:0] o_val
);

  logic [11:0] r_val;

  // Hundreds can only carry out at 999, which is blocked by the saturation test
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_val <= 12'h000;
    end else if (i_inc && (r_val != BCD_MAX)) begin
      r_val[3:0] <= bcdDigitInc(r_val[3:0]);
      if (r_val[3:0] == 4'd9) begin
        r_val[7:4] <= bcdDigitInc(r_val[7:4]);
        if (r_val[7:4] == 4'd9) begin
          r_val[11:8] <= bcdDigitInc(r_val[11:8]);
        end
      end
    end
  end

  assign o_val = r_val;

endmodule

// File: rtl/detector_coliziune.sv
// Collision detector and game-state FSM: samples the obstacle one cycle
// after each movement tick, flags hits, and keeps the BCD score.
module detector_coliziune
  import detector_coliziune_pkg::*;
(
  input  logic        i_clk_148Mhz,
  input  logic        i_reset,
  input  logic        i_tick_obs,
  input  logic        i_start,
  input  logic [10:0] i_x_obs,
  input  logic [10:0] i_y_gap,
  input  logic [10:0] i_y_player,
  output logic [1:0]  o_stare,
  output logic        o_run_en,
  output logic        o_coliziune,
  output logic [11:0] o_scor,
  output logic        o_flash
);

  stare_t      r_stare;
  logic        r_tickD;
  logic        r_runEn;
  logic        r_coliziune;
  logic        r_flash;
  logic        r_passed;
  logic [4:0]  r_hitCnt;

  logic [11:0] w_x;
  logic [11:0] w_yGap;
  logic [11:0] w_yPlayer;
  logic        w_onScreen;
  logic        w_hOverlap;
  logic        w_vOut;
  logic        w_hit;
  logic        w_scoreCond;
  logic        w_scorInc;
  logic        w_scorClr;

  assign w_x       = {1'b0, i_x_obs};
  assign w_yGap    = {1'b0, i_y_gap};
  assign w_yPlayer = {1'b0, i_y_player};

  // A wrapped-around x (large value) counts as off-screen and never hits
  assign w_onScreen  = (w_x < LUNGIME_ECRAN);
  assign w_hOverlap  = (w_x < (X_PLAYER + PLAYER_SIZE)) &&
                       ((w_x + LATIME_OBSTACOL) > X_PLAYER);
  assign w_vOut      = (w_yPlayer < w_yGap) ||
                       ((w_yPlayer + PLAYER_SIZE) > (w_yGap + GAP_H));
  assign w_hit       = w_onScreen && w_hOverlap && w_vOut;
  assign w_scoreCond = !r_passed && ((w_x + LATIME_OBSTACOL) <= X_PLAYER);

  assign w_scorInc = (r_stare == ST_RUN) && r_tickD && !w_hit && w_scoreCond;
  assign w_scorClr = i_start && ((r_stare == ST_IDLE) || (r_stare == ST_GAME_OVER));

  always_ff @(posedge i_clk_148Mhz) begin
    if (i_reset) begin
      r_stare     <= ST_IDLE;
      r_tickD     <= 1'b0;
      r_runEn     <= 1'b0;
      r_coliziune <= 1'b0;
      r_flash     <= 1'b0;
      r_passed    <= 1'b0;
      r_hitCnt    <= 5'd0;
    end else begin
      r_tickD     <= i_tick_obs;
      r_coliziune <= 1'b0;
      case (r_stare)
        ST_IDLE, ST_GAME_OVER: begin
          if (i_start) begin
            r_stare  <= ST_RUN;
            r_runEn  <= 1'b1;
            r_passed <= 1'b0;
            r_flash  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (r_tickD) begin
            if (w_hit) begin
              r_stare     <= ST_HIT;
              r_runEn     <= 1'b0;
              r_coliziune <= 1'b1;
              r_hitCnt    <= HIT_TICKS - 5'd1;
              r_flash     <= 1'b0;
            end else if (w_scoreCond) begin
              r_passed <= 1'b1;
            end else if (r_passed && (w_x >= (X_PLAYER + PLAYER_SIZE))) begin
              r_passed <= 1'b0;
            end
          end
        end
        ST_HIT: begin
          // The tick that finds the counter already at zero ends the flash
          if (r_tickD) begin
            if (r_hitCnt == 5'd0) begin
              r_stare <= ST_GAME_OVER;
              r_flash <= 1'b0;
            end else begin
              r_flash  <= ~r_flash;
              r_hitCnt <= r_hitCnt - 5'd1;
            end
          end
        end
        default: r_stare <= ST_IDLE;
      endcase
    end
  end

  contor_bcd3 u_scor (
    .i_clk   (i_clk_148Mhz),
    .i_reset (i_reset),
    .i_clr   (w_scorClr),
    .i_inc   (w_scorInc),
    .o_val   (o_scor)
  );

  assign o_stare     = r_stare;
  assign o_run_en    = r_runEn;
  assign o_coliziune = r_coliziune;
  assign o_flash     = r_flash;

endmodule
